// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter and bus-hold sequencer.
// Picks one unmasked requesting channel, asks the CPU for the bus (HRQ), waits for HLDA and
// then grants that channel with a one-hot DACK. The grant is held for one transfer (single
// mode) or until terminal count / EOP (block mode). Priority is fixed or rotating.
module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] mask,
  input  logic              priorityType,
  input  logic [NUM_CH-1:0] blockMode,
  input  logic              HLDA,
  input  logic              EOP_N,
  input  logic              tcIn,
  input  logic              cycleDone,
  input  logic              statusRd,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeCh,
  output logic              grantValid,
  output logic [NUM_CH-1:0] requestStatus,
  output logic [NUM_CH-1:0] tcStatus
);

  typedef enum logic [1:0] {StIdle, StReq, StGrant, StRelease} state_e;

  localparam logic [CH_W:0] NumChW = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  state_e            state;
  logic [CH_W-1:0]   ptr;

  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   searchBase;
  logic [NUM_CH-1:0] rotated;
  logic [CH_W-1:0]   winOffset;
  logic [CH_W:0]     winSum;
  logic [CH_W-1:0]   winner;
  logic [NUM_CH-1:0] winnerOneHot;
  logic [CH_W-1:0]   ptrInc;
  logic              endTc;
  logic              endGrant;
  logic [NUM_CH-1:0] tcKeep;

  // Arbitration: rotate pending so the search base sits at bit 0, take the lowest set bit,
  // then map the offset back to a channel index modulo NUM_CH.
  always_comb begin
    pending    = DREQ & ~mask;
    searchBase = priorityType ? ptr : '0;
    rotated    = NUM_CH'({pending, pending} >> searchBase);
    winOffset  = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rotated[j]) winOffset = CH_W'(j);
    end
    winSum = {1'b0, searchBase} + {1'b0, winOffset};
    if (winSum >= NumChW) winSum = winSum - NumChW;
    winner = winSum[CH_W-1:0];
    winnerOneHot = '0;
    winnerOneHot[winner] = 1'b1;
  end

  // Termination decode for the active grant and sticky-status clear.
  always_comb begin
    endTc    = !EOP_N || (cycleDone && tcIn);
    endGrant = endTc || (cycleDone && !blockMode[activeCh]);
    ptrInc   = (activeCh == LastCh) ? '0 : activeCh + CH_W'(1);
    tcKeep   = statusRd ? '0 : tcStatus;
  end

  // Sequencer with registered outputs; a termination set overrides a same-cycle status clear.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state         <= StIdle;
      ptr           <= '0;
      HRQ           <= 1'b0;
      DACK          <= '0;
      activeCh      <= '0;
      grantValid    <= 1'b0;
      requestStatus <= '0;
      tcStatus      <= '0;
    end else begin
      requestStatus <= pending;
      tcStatus      <= tcKeep;
      case (state)
        StIdle: begin
          if (|pending) begin
            HRQ   <= 1'b1;
            state <= StReq;
          end
        end
        StReq: begin
          if (HLDA) begin
            if (|pending) begin
              activeCh   <= winner;
              DACK       <= winnerOneHot;
              grantValid <= 1'b1;
              state      <= StGrant;
            end else begin
              // Request withdrawn before the bus arrived: hand the bus back.
              HRQ   <= 1'b0;
              state <= StRelease;
            end
          end
        end
        StGrant: begin
          if (!HLDA) begin
            // Bus revoked: drop the grant without touching priority or status.
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
            state      <= StIdle;
          end else if (endGrant) begin
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
            if (endTc) tcStatus <= tcKeep | DACK;
            ptr        <= priorityType ? ptrInc : '0;
            state      <= StRelease;
          end
        end
        StRelease: begin
          if (!HLDA) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: the driver predicts each grant and each grant end
// from a transaction-level model and queues them; a negedge monitor checks what the DUT shows.
module tb_dma_channel_arbiter;

  typedef struct packed {
    logic [3:0] tc;
    logic       chkHrq;
  } endExp_t;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ, mask, blockMode;
  logic       priorityType, HLDA, EOP_N, tcIn, cycleDone, statusRd;
  logic       HRQ, grantValid;
  logic [3:0] DACK, requestStatus, tcStatus;
  logic [1:0] activeCh;

  logic       rst8, hlda8, hrq8, gv8;
  logic [7:0] dreq8, dack8, rs8, tc8;
  logic [2:0] ach8;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .mask(mask), .priorityType(priorityType),
    .blockMode(blockMode), .HLDA(HLDA), .EOP_N(EOP_N), .tcIn(tcIn), .cycleDone(cycleDone),
    .statusRd(statusRd), .HRQ(HRQ), .DACK(DACK), .activeCh(activeCh), .grantValid(grantValid),
    .requestStatus(requestStatus), .tcStatus(tcStatus)
  );

  dma_channel_arbiter #(.NUM_CH(8)) dut8 (
    .CLK(CLK), .RESET_N(rst8), .DREQ(dreq8), .mask(8'h00), .priorityType(1'b0),
    .blockMode(8'h00), .HLDA(hlda8), .EOP_N(1'b1), .tcIn(1'b0), .cycleDone(1'b0),
    .statusRd(1'b0), .HRQ(hrq8), .DACK(dack8), .activeCh(ach8), .grantValid(gv8),
    .requestStatus(rs8), .tcStatus(tc8)
  );

  int vectors = 0;
  int miscompares = 0;

  int         mPtr = 0;
  logic [3:0] mTc = 4'b0;
  int         gq[$];
  endExp_t    eq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference arbitration: first requesting channel at or after the base, wrapping.
  function automatic int modelWinner(input logic [3:0] pend);
    int base;
    base = priorityType ? mPtr : 0;
    for (int i = 0; i < 4; i++) begin
      if (pend[(base + i) % 4]) return (base + i) % 4;
    end
    return 0;
  endfunction

  function automatic void modelEnd(input int ch);
    mPtr = priorityType ? (ch + 1) % 4 : 0;
  endfunction

  // Monitor: grant start/end events, DACK stability and the registered request copy.
  logic       prevGv = 1'b0;
  logic [3:0] curDack = 4'b0;
  logic [3:0] expRs = 4'b0;
  always @(negedge CLK) begin : monitor
    int      ch;
    endExp_t e;
    chk("requestStatus", requestStatus, expRs);
    expRs = RESET_N ? (DREQ & ~mask) : 4'b0;
    if (grantValid && !prevGv) begin
      if (gq.size() == 0) begin
        chk("grantUnexpected", grantValid, 1'b0);
      end else begin
        ch = gq.pop_front();
        curDack = 4'b1 << ch;
        chk("grantDack", DACK, curDack);
        chk("grantCh", activeCh, ch);
      end
    end else if (!grantValid && prevGv) begin
      if (eq.size() == 0) begin
        chk("endUnexpected", grantValid, 1'b1);
      end else begin
        e = eq.pop_front();
        chk("endTcStatus", tcStatus, e.tc);
        if (e.chkHrq) chk("endHrq", HRQ, 1'b0);
      end
    end
    if (grantValid) chk("dackHeld", DACK, curDack);
    else chk("dackIdle", DACK, 4'b0);
    prevGv = grantValid;
  end

  task automatic waitHrq();
    int n;
    n = 0;
    while (!HRQ && n < 10) begin
      tick();
      n++;
    end
    chk("hrqRaise", HRQ, 1'b1);
  endtask

  task automatic drain();
    DREQ = 4'b0;
    if (HRQ) begin
      HLDA = 1'b1;
      tick();
      HLDA = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic releasePhase(input bit doRd);
    logic [3:0] pendNow;
    repeat ($urandom_range(0, 2)) tick();
    if (doRd) begin
      statusRd = 1'b1;
      mTc = 4'b0;
      tick();
      statusRd = 1'b0;
    end
    HLDA = 1'b0;
    tick();
    chk("hrqInRelease", HRQ, 1'b0);
    pendNow = DREQ & ~mask;
    tick();
    chk("reRequest", HRQ, pendNow != 4'b0);
    chk("tcStatusIdle", tcStatus, mTc);
  endtask

  // kind: 0 = cycleDone-terminated, 1 = EOP, 2 = HLDA revoked, 3 = request withdrawn.
  task automatic doTxn(input logic [3:0] dq, input logic [3:0] mk, input logic [3:0] bm,
                       input int kind, input int nPulses, input int hldaDelay,
                       input bit rdAtEnd, input bit rdInRelease);
    logic [3:0] pend;
    int         ch;
    endExp_t    e;
    bit         tcv;
    bit         last;
    DREQ = dq;
    mask = mk;
    blockMode = bm;
    pend = dq & ~mk;
    waitHrq();
    if (kind == 3) begin
      repeat (hldaDelay) tick();
      DREQ = 4'b0;
      HLDA = 1'b1;
      tick();
      chk("withdrawHrq", HRQ, 1'b0);
      chk("withdrawGv", grantValid, 1'b0);
      HLDA = 1'b0;
      tick();
      tick();
      return;
    end
    ch = modelWinner(pend);
    gq.push_back(ch);
    repeat (hldaDelay) tick();
    HLDA = 1'b1;
    tick();
    chk("grantLatency", grantValid, 1'b1);
    mask = 4'($urandom);
    if (bm[ch]) DREQ = 4'($urandom);
    if (kind == 2) begin
      repeat ($urandom_range(0, 3)) tick();
      e.tc = mTc;
      e.chkHrq = 1'b0;
      eq.push_back(e);
      HLDA = 1'b0;
      DREQ = 4'b0;
      tick();
      tick();
      chk("hrqAfterRevoke", HRQ, 1'b0);
      return;
    end
    if (kind == 1) begin
      repeat ($urandom_range(0, 3)) tick();
      EOP_N = 1'b0;
      cycleDone = 1'($urandom);
      tcIn = 1'($urandom);
      statusRd = rdAtEnd;
      mTc = (rdAtEnd ? 4'b0 : mTc) | (4'b1 << ch);
      e.tc = mTc;
      e.chkHrq = 1'b1;
      eq.push_back(e);
      modelEnd(ch);
      tick();
      EOP_N = 1'b1;
      cycleDone = 1'b0;
      tcIn = 1'b0;
      statusRd = 1'b0;
    end else begin
      for (int p = 1; p <= nPulses; p++) begin
        repeat ($urandom_range(0, 2)) tick();
        last = (p == nPulses) || !bm[ch];
        cycleDone = 1'b1;
        if (last) begin
          tcv = bm[ch] ? 1'b1 : 1'($urandom);
          tcIn = tcv;
          statusRd = rdAtEnd;
          mTc = (rdAtEnd ? 4'b0 : mTc) | (tcv ? (4'b1 << ch) : 4'b0);
          e.tc = mTc;
          e.chkHrq = 1'b1;
          eq.push_back(e);
          modelEnd(ch);
        end
        tick();
        cycleDone = 1'b0;
        tcIn = 1'b0;
        statusRd = 1'b0;
        if (last) break;
      end
    end
    releasePhase(rdInRelease);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin : driver
    logic [3:0] dq, mk;
    int         b, kindSel, kind, n;
    RESET_N = 1'b0; rst8 = 1'b0;
    DREQ = 4'hf; mask = 4'b0; blockMode = 4'b0; priorityType = 1'b0;
    HLDA = 1'b1; EOP_N = 1'b1; tcIn = 1'b0; cycleDone = 1'b0; statusRd = 1'b0;
    hlda8 = 1'b0; dreq8 = 8'h00;
    tick();
    tick();
    chk("rstHrq", HRQ, 1'b0);
    chk("rstDack", DACK, 4'b0);
    chk("rstActiveCh", activeCh, 2'd0);
    chk("rstGrantValid", grantValid, 1'b0);
    chk("rstRequestStatus", requestStatus, 4'b0);
    chk("rstTcStatus", tcStatus, 4'b0);
    RESET_N = 1'b1; rst8 = 1'b1;
    DREQ = 4'b0; HLDA = 1'b0;
    tick();

    // Fixed priority, HLDA late: channel 1 wins over 3.
    doTxn(4'b1010, 4'b0, 4'b0, 0, 1, 3, 1'b0, 1'b0);
    // Rotating priority with all channels requesting: 0,1,2,3,0.
    priorityType = 1'b1;
    repeat (5) doTxn(4'hf, 4'b0, 4'b0, 0, 1, 0, 1'b0, 1'b0);
    drain();
    // A masked request never raises HRQ; unmasking raises it one edge later.
    DREQ = 4'b0001;
    mask = 4'b0001;
    repeat (10) tick();
    chk("maskedHrq", HRQ, 1'b0);
    mask = 4'b0;
    tick();
    chk("unmaskHrq", HRQ, 1'b1);
    doTxn(4'b0001, 4'b0, 4'b0, 0, 1, 1, 1'b0, 1'b0);
    // Block mode on channel 2 with three transfers, then a status read.
    doTxn(4'b0100, 4'b0, 4'b0100, 0, 3, 0, 1'b0, 1'b1);
    // EOP mid-block, then HLDA revoked mid-grant, then a grant that exposes the pointer.
    doTxn(4'b0010, 4'b0, 4'b0010, 1, 0, 0, 1'b0, 1'b0);
    doTxn(4'b1000, 4'b0, 4'b1000, 2, 0, 0, 1'b0, 1'b0);
    doTxn(4'hf, 4'b0, 4'b0, 0, 1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      priorityType = 1'($urandom);
      dq = 4'($urandom_range(1, 15));
      do b = $urandom_range(0, 3); while (!dq[b]);
      mk = 4'($urandom) & ~(4'b1 << b);
      kindSel = $urandom_range(0, 9);
      kind = (kindSel < 6) ? 0 : (kindSel < 8) ? 1 : (kindSel == 8) ? 2 : 3;
      doTxn(dq, mk, 4'($urandom), kind, $urandom_range(1, 3), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    drain();

    // Eight-channel instance: grant channel 7, then reset mid-grant.
    dreq8 = 8'h80;
    n = 0;
    while (!hrq8 && n < 10) begin
      tick();
      n++;
    end
    chk("hrq8Raise", hrq8, 1'b1);
    hlda8 = 1'b1;
    tick();
    chk("dack8Grant", dack8, 8'h80);
    chk("ach8Grant", ach8, 3'd7);
    rst8 = 1'b0;
    tick();
    chk("rst8Hrq", hrq8, 1'b0);
    chk("rst8Dack", dack8, 8'h00);
    chk("rst8ActiveCh", ach8, 3'd0);
    chk("rst8GrantValid", gv8, 1'b0);
    chk("rst8RequestStatus", rs8, 8'h00);
    chk("rst8TcStatus", tc8, 8'h00);
    rst8 = 1'b1;
    tick();
    chk("idle8Hrq", hrq8, 1'b1);
    chk("idle8Gv", gv8, 1'b0);
    tick();
    chk("regrant8", dack8, 8'h80);

    tick();
    chk("grantsLeft", gq.size(), 0);
    chk("endsLeft", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Parametrised N-channel request arbiter and bus-hold sequencer for the DMA controller. It samples unmasked DREQ lines, raises HRQ to the CPU, waits for HLDA, then grants exactly one channel via a one-hot DACK. The grant is held for one transfer (single mode) or until terminal count or EOP (block mode). It generalises the 4-channel fixed/rotating priority logic to NUM_CH channels, adds per-channel single/block mode, HLDA revocation handling and sticky terminal-count status, and sits between the register file and the timing-control state machine.

## Interface
- NUM_CH, default 4: number of DMA channels; legal values 2..16.
- CH_W, default $clog2(NUM_CH): width of the channel index; derived, never overridden.

- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- DREQ  in  NUM_CH  channel requests, active high.
- mask  in  NUM_CH  per-channel mask from the register file; 1 blocks the request.
- priorityType  in  1  0 = fixed (channel 0 highest), 1 = rotating.
- blockMode  in  NUM_CH  per channel: 0 = single transfer, 1 = block transfer.
- HLDA  in  1  hold acknowledge from the CPU.
- EOP_N  in  1  external end-of-process, active low.
- tcIn  in  1  terminal count of the active channel, from the datapath.
- cycleDone  in  1  one-cycle pulse from timing control when one transfer completes.
- statusRd  in  1  one-cycle pulse that clears tcStatus.
- HRQ  out  1  hold request to the CPU.
- DACK  out  NUM_CH  one-hot grant; all zero when no grant.
- activeCh  out  CH_W  index of the granted channel; holds its last value when idle.
- grantValid  out  1  high while DACK is nonzero.
- requestStatus  out  NUM_CH  registered copy of DREQ & ~mask.
- tcStatus  out  NUM_CH  sticky per-channel terminal-count flags.

## Operation
- pending = DREQ & ~mask.
- Winner selection: first set bit of pending, searching upward from pointer ptr with wrap at NUM_CH.
  - Fixed mode: ptr = 0 always.
  - Rotating mode: when a grant to channel k ends normally, ptr <= (k+1) mod NUM_CH. Reset sets ptr = 0.
- States: IDLE, REQ, GRANT, RELEASE. Reset enters IDLE.
- IDLE
  - pending != 0: HRQ <= 1, go to REQ.
  - pending == 0: remain in IDLE.
- REQ
  - HLDA = 0: hold HRQ and wait indefinitely.
  - HLDA = 1 and pending != 0: re-arbitrate on the current pending, load activeCh, assert DACK[winner] and grantValid, go to GRANT.
  - HLDA = 1 and pending == 0 (request withdrawn): go to RELEASE.
- GRANT
  - EOP_N = 0 in any cycle: terminate. Set tcStatus[activeCh], go to RELEASE.
  - On cycleDone with tcIn = 1: terminate. Set tcStatus[activeCh], go to RELEASE.
  - On cycleDone with blockMode[activeCh] = 0: go to RELEASE without setting tcStatus.
  - On cycleDone with blockMode[activeCh] = 1: stay in GRANT. DREQ deassertion does not end a block grant.
  - HLDA = 0 (revocation): clear DACK and grantValid, go to IDLE directly. Do not update ptr or tcStatus.
- RELEASE
  - On entry: HRQ, DACK and grantValid are 0, and ptr is updated (rotating mode).
  - Wait for HLDA = 0, then go to IDLE.
  - New requests are not served until IDLE is re-entered.
- Masking a channel while it is granted does not end the grant; the mask only affects new arbitration.
- tcStatus: a bit is set on termination and cleared by statusRd. If set and clear hit the same bit in the same cycle, set wins.

## Timing
- Every output is registered. Reset values: HRQ = 0, DACK = 0, activeCh = 0, grantValid = 0, requestStatus = 0, tcStatus = 0, ptr = 0.
- pending sampled nonzero at edge t in IDLE: HRQ is high after edge t.
- HLDA sampled high at edge t in REQ: DACK is valid after edge t.
- Minimum DREQ-to-DACK latency is 2 cycles when HLDA is already high.
- Termination at edge t: DACK = 0 and HRQ = 0 after edge t. The tcStatus bit is visible in the same cycle.
- A single-mode channel with DREQ still high is re-requested no earlier than 2 cycles after HLDA falls (RELEASE → IDLE → REQ).
- RESET_N low at any edge, including mid-GRANT: all outputs drop to their reset values after that edge and the state returns to IDLE. Reset overrides every other input.
- EOP_N and cycleDone/tcIn in the same cycle: a single termination. tcStatus is set once.

## Test plan
- Fixed priority, NUM_CH = 4, mask = 0, DREQ = 4'b1010, HLDA raised 3 cycles after HRQ -> DACK = 4'b0010 one cycle after HLDA is sampled; activeCh = 1.
- Rotating priority, DREQ = 4'b1111 held, all channels single mode -> grant order 0, 1, 2, 3, 0; DACK is never multi-hot.
- Mask = 4'b0001, DREQ = 4'b0001 -> HRQ stays 0 indefinitely. Unmasking gives HRQ = 1 one cycle later.
- Channel 2 in block mode with 3 cycleDone pulses, tcIn on the third -> DACK = 4'b0100 throughout, tcStatus = 4'b0100, HRQ falls with DACK. A later statusRd returns tcStatus to 0.
- EOP_N pulsed low mid-block, and separately HLDA dropped mid-GRANT -> EOP case: terminate and set tcStatus. HLDA case: DACK = 0 next cycle, tcStatus unchanged, ptr unchanged.
- NUM_CH = 8, DREQ = 8'h80, RESET_N asserted during GRANT -> DACK = 8'h80 before reset; all outputs zero after the reset edge; state is IDLE.
